// File: rtl/seg_driver_pkg.sv
// Shared definitions for the multiplexed three-digit seven-segment driver:
// digit count, FSM state codes and the active-low hex glyph table.
package seg_driver_pkg;

    localparam int NUM_DIGITS = 3;

    typedef enum logic {
        STATE_BLANK = 1'b0,
        STATE_SHOW  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [2:0] AN_OFF    = 3'b111;

    // Segment patterns, seg[6:0] = g..a, a lit segment is driven low
    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'h40,  // 0
        7'h79,  // 1
        7'h24,  // 2
        7'h30,  // 3
        7'h19,  // 4
        7'h12,  // 5
        7'h02,  // 6
        7'h78,  // 7
        7'h00,  // 8
        7'h10,  // 9
        7'h08,  // A
        7'h03,  // b
        7'h46,  // C
        7'h21,  // d
        7'h06,  // E
        7'h0E   // F
    };

    // Active-low one-hot anode pattern for a digit index
    function automatic logic [2:0] anodeSelect(input logic [1:0] digitIdx);
        return ~(3'b001 << digitIdx);
    endfunction

endpackage

// File: rtl/seg_driver_hex_decoder.sv
// Purely combinational hex nibble to active-low seven-segment decoder.
module seg_hex_decoder
    import seg_driver_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    // Table lookup into the shared glyph table
    always_comb begin
        o_seg = SEG_PATTERNS[i_hex];
    end

endmodule

// File: rtl/seg_driver.sv
// Time-multiplexed driver for a three-digit common-anode display.
// Each digit owns a slot of DIGIT_CYCLES clocks whose first BLANK_CYCLES
// are dark to suppress ghosting. The input value is latched once per frame
// so a frame never mixes two different input words.
module seg_driver
    import seg_driver_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] seg_digits,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [2:0]  an
);

    localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGIT_CYCLES - 1);
    localparam state_t RESET_STATE = (BLANK_CYCLES == 0) ? STATE_SHOW : STATE_BLANK;

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    state_t           r_state;
    logic [11:0]      r_shd;
    logic [6:0]       r_seg;
    logic [2:0]       r_an;
    logic             r_dp;

    logic [CNT_W-1:0] w_cntNext;
    logic [1:0]       w_idxNext;
    logic             w_wrap;
    logic             w_frameStart;
    logic [11:0]      w_frameDigits;
    logic [3:0]       w_nibble;
    logic [6:0]       w_decoded;
    state_t           w_nextState;
    logic [2:0]       w_anNext;
    logic [6:0]       w_segNext;

    // Slot counter and digit index successors; idx steps only on slot wrap
    always_comb begin
        w_wrap    = (r_cnt == CNT_MAX);
        w_cntNext = w_wrap ? '0 : r_cnt + 1'b1;
        w_idxNext = r_idx;
        if (w_wrap) begin
            w_idxNext = (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
        end
    end

    // During the frame-start cycle the shadow is still stale, so the live
    // input is used directly; that is exactly the value being latched
    always_comb begin
        w_frameStart  = (r_cnt == '0) && (r_idx == 2'd0);
        w_frameDigits = w_frameStart ? seg_digits : r_shd;
        case (r_idx)
            2'd0:    w_nibble = w_frameDigits[3:0];
            2'd1:    w_nibble = w_frameDigits[7:4];
            default: w_nibble = w_frameDigits[11:8];
        endcase
    end

    seg_hex_decoder u_decoder (
        .i_hex (w_nibble),
        .o_seg (w_decoded)
    );

    // FSM next state tracks the upcoming counter value; output decode
    // from the present state feeds the output registers
    always_comb begin
        w_nextState = STATE_SHOW;
        w_anNext    = AN_OFF;
        w_segNext   = SEG_BLANK;
        if (int'(w_cntNext) < BLANK_CYCLES) begin
            w_nextState = STATE_BLANK;
        end
        if (r_state == STATE_SHOW) begin
            w_anNext  = anodeSelect(r_idx);
            w_segNext = w_decoded;
        end
    end

    // Slot position within the frame; reset discards any partial slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else begin
            r_cnt <= w_cntNext;
            r_idx <= w_idxNext;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Shadow copy of the input, refreshed only at frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shd <= 12'h000;
        end else if (w_frameStart) begin
            r_shd <= seg_digits;
        end
    end

    // Registered pad outputs; decimal point is never lit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_anNext;
            r_seg <= w_segNext;
            r_dp  <= 1'b1;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_seg_driver.sv
// Self-checking bench for seg_driver. Two instances run side by side:
// A with an 8-cycle slot and 2 blank cycles, B with a 2-cycle slot and no
// blanking. A frame-position reference model predicts every output.
module tb_seg_driver;

    localparam int D_A = 8;
    localparam int B_A = 2;
    localparam int D_B = 2;
    localparam int B_B = 0;

    logic        clk;
    logic        rst;
    logic [11:0] segDigits;
    logic [6:0]  segA, segB;
    logic        dpA, dpB;
    logic [2:0]  anA, anB;

    int errors = 0;
    int checks = 0;

    logic [6:0] hexGlyph [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seg_driver #(.DIGIT_CYCLES(D_A), .BLANK_CYCLES(B_A)) dutA (
        .clk        (clk),
        .rst        (rst),
        .seg_digits (segDigits),
        .seg        (segA),
        .dp         (dpA),
        .an         (anA)
    );

    seg_driver #(.DIGIT_CYCLES(D_B), .BLANK_CYCLES(B_B)) dutB (
        .clk        (clk),
        .rst        (rst),
        .seg_digits (segDigits),
        .seg        (segB),
        .dp         (dpB),
        .an         (anB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {an, seg} at frame position p for a frame showing val
    function automatic logic [9:0] modelOut(input int p, input logic [11:0] val,
                                            input int d, input int b);
        int slotPos;
        int digit;
        logic [3:0] nib;
        slotPos = p % d;
        digit   = (p / d) % 3;
        if (slotPos < b) return {3'b111, 7'h7F};
        nib = val[digit*4 +: 4];
        return {~(3'b001 << digit), hexGlyph[nib]};
    endfunction

    // Reference model: position counts clock edges since release, and the
    // frame value is whatever the input held at each frame's first cycle
    int          posA = 0, posB = 0;
    logic [11:0] frameA, frameB;
    logic [2:0]  expAnA = 3'b111, expAnB = 3'b111;
    logic [6:0]  expSegA = 7'h7F, expSegB = 7'h7F;

    always @(posedge clk) begin
        if (rst) begin
            posA = 0; posB = 0;
            expAnA = 3'b111; expSegA = 7'h7F;
            expAnB = 3'b111; expSegB = 7'h7F;
        end else begin
            if (posA % (3*D_A) == 0) frameA = segDigits;
            if (posB % (3*D_B) == 0) frameB = segDigits;
            {expAnA, expSegA} = modelOut(posA, frameA, D_A, B_A);
            {expAnB, expSegB} = modelOut(posB, frameB, D_B, B_B);
            posA++;
            posB++;
        end
    end

    task automatic applyStimulus(input logic r, input logic [11:0] digits);
        rst       = r;
        segDigits = digits;
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 12'hABC);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (anA !== 3'b111) begin errors++; $display("[TB] FAIL reset_anA cycle %0d got %b want 111", k, anA); end
            checks++;
            if (segA !== 7'h7F) begin errors++; $display("[TB] FAIL reset_segA cycle %0d got %h want 7f", k, segA); end
            checks++;
            if (dpA !== 1'b1) begin errors++; $display("[TB] FAIL reset_dpA cycle %0d got %b want 1", k, dpA); end
            checks++;
            if (anB !== 3'b111 || segB !== 7'h7F || dpB !== 1'b1) begin
                errors++; $display("[TB] FAIL reset_B cycle %0d got an=%b seg=%h dp=%b", k, anB, segB, dpB);
            end
        end
    endtask

    // Release with 123 and check the documented slot timing on instance A
    task automatic test_release_timing(input string tag);
        applyStimulus(1'b0, 12'h123);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            checks++;
            if (anA !== expAnA || segA !== expSegA) begin
                errors++; $display("[TB] FAIL %s_model cycle %0d got an=%b seg=%b want an=%b seg=%b", tag, k, anA, segA, expAnA, expSegA);
            end
            checks++;
            if (k <= 2 && anA !== 3'b111) begin errors++; $display("[TB] FAIL %s_lead_blank cycle %0d got %b want 111", tag, k, anA); end
            checks++;
            if (k >= 3 && k <= 8 && (anA !== 3'b110 || segA !== 7'b0110000)) begin
                errors++; $display("[TB] FAIL %s_digit0 cycle %0d got an=%b seg=%b want an=110 seg=0110000", tag, k, anA, segA);
            end
            checks++;
            if ((k == 9 || k == 10) && (anA !== 3'b111 || segA !== 7'h7F)) begin
                errors++; $display("[TB] FAIL %s_gap cycle %0d got an=%b seg=%h want 111/7f", tag, k, anA, segA);
            end
            checks++;
            if (k >= 11 && k <= 16 && (anA !== 3'b101 || segA !== 7'b0100100)) begin
                errors++; $display("[TB] FAIL %s_digit1 cycle %0d got an=%b seg=%b want an=101 seg=0100100", tag, k, anA, segA);
            end
            checks++;
            if (k >= 19 && k <= 24 && (anA !== 3'b011 || segA !== 7'b1111001)) begin
                errors++; $display("[TB] FAIL %s_digit2 cycle %0d got an=%b seg=%b want an=011 seg=1111001", tag, k, anA, segA);
            end
        end
    endtask

    task automatic test_mid_frame_change();
        applyStimulus(1'b1, 12'h123);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 12'h123);
        for (int k = 1; k <= 48; k++) begin
            @(negedge clk);
            if (k == 12) segDigits = 12'h8F0;
            checks++;
            if (anA !== expAnA || segA !== expSegA) begin
                errors++; $display("[TB] FAIL midframe_model cycle %0d got an=%b seg=%b want an=%b seg=%b", k, anA, segA, expAnA, expSegA);
            end
            checks++;
            if (k >= 19 && k <= 24 && (anA !== 3'b011 || segA !== 7'b1111001)) begin
                errors++; $display("[TB] FAIL midframe_old_digit2 cycle %0d got an=%b seg=%b want 011/1111001", k, anA, segA);
            end
            checks++;
            if (k >= 27 && k <= 32 && (anA !== 3'b110 || segA !== 7'b1000000)) begin
                errors++; $display("[TB] FAIL midframe_new0 cycle %0d got an=%b seg=%b want 110/1000000", k, anA, segA);
            end
            checks++;
            if (k >= 35 && k <= 40 && (anA !== 3'b101 || segA !== 7'b0001110)) begin
                errors++; $display("[TB] FAIL midframe_newF cycle %0d got an=%b seg=%b want 101/0001110", k, anA, segA);
            end
            checks++;
            if (k >= 43 && k <= 48 && (anA !== 3'b011 || segA !== 7'b0000000)) begin
                errors++; $display("[TB] FAIL midframe_new8 cycle %0d got an=%b seg=%b want 011/0000000", k, anA, segA);
            end
        end
    endtask

    // Five frames of random held digits; anodes stay one-hot-low
    task automatic test_wrap();
        segDigits = 12'($urandom);
        for (int k = 1; k <= 5*3*D_A; k++) begin
            @(negedge clk);
            checks++;
            if (anA !== expAnA || segA !== expSegA) begin
                errors++; $display("[TB] FAIL wrap_A cycle %0d got an=%b seg=%b want an=%b seg=%b", k, anA, segA, expAnA, expSegA);
            end
            checks++;
            if (anB !== expAnB || segB !== expSegB) begin
                errors++; $display("[TB] FAIL wrap_B cycle %0d got an=%b seg=%b want an=%b seg=%b", k, anB, segB, expAnB, expSegB);
            end
            checks++;
            if ($countones(~anA) > 1 || $countones(~anB) > 1) begin
                errors++; $display("[TB] FAIL wrap_onehot cycle %0d got anA=%b anB=%b want at most one low", k, anA, anB);
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (anA !== 3'b111 || segA !== 7'h7F) begin
            errors++; $display("[TB] FAIL midreset_blank got an=%b seg=%h want 111/7f", anA, segA);
        end
        @(negedge clk);
        test_release_timing("rerelease");
    endtask

    // Random input changes at arbitrary times; model enforces per-frame capture
    task automatic test_random();
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            checks++;
            if (anA !== expAnA || segA !== expSegA || dpA !== 1'b1) begin
                errors++; $display("[TB] FAIL random_A cycle %0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=1", k, anA, segA, dpA, expAnA, expSegA);
            end
            checks++;
            if (anB !== expAnB || segB !== expSegB || dpB !== 1'b1) begin
                errors++; $display("[TB] FAIL random_B cycle %0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=1", k, anB, segB, dpB, expAnB, expSegB);
            end
            if ($urandom_range(9) == 0) segDigits = 12'($urandom);
        end
    endtask

    // DIGIT_CYCLES=2, BLANK_CYCLES=0: no dark cycles, each anode low for two
    task automatic test_corner();
        logic [2:0] wantAn;
        applyStimulus(1'b1, 12'h5A7);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 12'h5A7);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            wantAn = ~(3'b001 << (((k - 1) / 2) % 3));
            checks++;
            if (anB !== wantAn) begin
                errors++; $display("[TB] FAIL corner_an cycle %0d got %b want %b", k, anB, wantAn);
            end
            checks++;
            if (segB !== expSegB) begin
                errors++; $display("[TB] FAIL corner_seg cycle %0d got %b want %b", k, segB, expSegB);
            end
        end
    endtask

    initial begin
        applyStimulus(1'b1, 12'h000);
        test_reset();
        test_release_timing("release");
        test_mid_frame_change();
        test_wrap();
        test_reset_mid();
        test_random();
        test_corner();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_driver.md
SEG_DRIVER -- requirements
Module: seg_driver

Interface
REQ-001 Parameter DIGIT_CYCLES, default 50000, meaning clock cycles per digit slot (1 ms at 50 MHz); legal range >= 2.
REQ-002 Parameter BLANK_CYCLES, default 500, meaning blanked cycles at the start of each slot; legal range 0 <= BLANK_CYCLES < DIGIT_CYCLES.
REQ-003 Port clk, input, 1 bit, meaning the single system clock.
REQ-004 Port rst, input, 1 bit, meaning reset; synchronous, active-high.
REQ-005 Port seg_digits, input, 12 bits, meaning three hex digits from seg_status; [3:0] is digit 0 (rightmost), [11:8] is digit 2.
REQ-006 Port seg, output, 7 bits, meaning active-low segment cathodes, bit0=a through bit6=g.
REQ-007 Port dp, output, 1 bit, meaning active-low decimal point.
REQ-008 Port an, output, 3 bits, meaning active-low digit anodes; an[i] selects digit i.

Function
REQ-009 Slot counter cnt SHALL count 0..DIGIT_CYCLES-1 and wrap to 0; width $clog2(DIGIT_CYCLES).
REQ-010 Digit index idx SHALL advance 0->1->2->0 in the cycle cnt wraps; idx never takes value 3.
REQ-011 The FSM SHALL have two states: BLANK while cnt < BLANK_CYCLES, SHOW otherwise; with BLANK_CYCLES=0, BLANK is never entered.
REQ-012 Shadow register shd[11:0] SHALL capture seg_digits only in the cycle where cnt==0 and idx==0 (frame start).
REQ-013 seg_digits changes at any other time SHALL NOT affect the display until the next frame start; no frame mixes two input values.
REQ-014 seg, an, and dp SHALL be registered; each reflects the cnt/idx/state of the previous cycle (1-cycle latency).
REQ-015 BLANK output: an=3'b111 and seg=7'h7F.
REQ-016 SHOW output: an has only bit idx low, and seg = hex pattern of shd nibble idx.
REQ-017 Hex patterns (seg[6:0], active-low) for the standard 0-F glyphs, for example:
- 0 = 1000000
- 1 = 1111001
- 2 = 0100100
- 3 = 0110000
- 8 = 0000000
- A = 0001000
- F = 0001110
REQ-018 dp SHALL be constant 1 outside reset and within it.
REQ-019 At most one an bit SHALL be low in any cycle.
REQ-020 The first frame after reset SHALL display the seg_digits value sampled in the first cycle with rst low.

Reset
REQ-021 While rst=1 at a clk edge, the next-cycle values SHALL be:
- cnt=0, idx=0, state=BLANK (or SHOW if BLANK_CYCLES=0)
- shd=12'h000
- an=3'b111, seg=7'h7F, dp=1
REQ-022 Reset asserted mid-slot or mid-frame SHALL abort the current slot with no partial-slot carry-over; counting restarts at cnt=0, idx=0 after release.

Structure
REQ-023 The digit count (3) and the 16-entry segment pattern constants SHALL live in the shared definitions include alongside the STATE_* codes.
REQ-024 Hex-to-segment decoding SHALL be one combinational sub-module, seg_hex_decoder (4-bit in, 7-bit active-low out), instanced once and fed the idx-selected nibble.
REQ-025 The top-level SHALL wire seg_status.seg_digits directly to seg_driver.seg_digits with no intermediate logic.

Verification
All scenarios use DIGIT_CYCLES=8 and BLANK_CYCLES=2.
REQ-026 Reset hold: rst=1 for 3 cycles with seg_digits=12'hABC -> an=111, seg=7F, dp=1 throughout.
REQ-027 Release with seg_digits=12'h123:
- an=111 on cycles 1-2 after release
- an=110 with seg=0110000 ("3") on cycles 3-8
- cycles 9-10 blanked
- an=101 with seg=0100100 ("2") on cycles 11-16
- then "1" on an=011
REQ-028 Mid-frame change: seg_digits switches 12'h123 -> 12'h8F0 during digit 1's slot -> digit 2 still shows "1"; the next frame shows "0" on an=110, "F"=0001110 on an=101, and "8"=0000000 on an=011.
REQ-029 Wrap: run 5 full frames with seg_digits held -> idx sequence 0,1,2 repeats, one-hot-low anodes, no cycle with two anodes low.
REQ-030 Reset mid-operation: assert rst during digit 1's SHOW phase -> an=111 and seg=7F the next cycle; after release, timing matches REQ-027 exactly.
REQ-031 Parameter corner: BLANK_CYCLES=0, DIGIT_CYCLES=2 -> no blank cycles, and each anode is low for exactly 2 consecutive cycles.
